// File: rtl/dff_chk_pkg.sv
// Shared types and default parameters for the DFF stream checker.
// Optional toggle counting is enabled by defining DFF_CHK_TOGGLE_EN.
package dff_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_CHECK = 2'd2,
        ST_FAIL  = 2'd3
    } state_t;

    localparam int unsigned DEF_CNT_W     = 16;
    localparam int unsigned DEF_ERR_LIMIT = 4;

endpackage

// File: rtl/dff_chk_sat_cnt.sv
// Saturating up-counter with synchronous reset and clear.
// Reset wins over clear, and clear wins over increment.
module dff_chk_sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/dff_stream_checker.sv
// Checks a flip-flop's q/qbar against the data presented one edge earlier.
// Define DFF_CHK_TOGGLE_EN to add the tog_cnt output and its counter.
module dff_stream_checker
    import dff_chk_pkg::*;
#(
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned ERR_LIMIT = DEF_ERR_LIMIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             d,
    input  logic             q,
    input  logic             qbar,
    output logic             busy,
    output logic             mismatch,
    output logic             fail,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] chk_cnt
`ifdef DFF_CHK_TOGGLE_EN
    ,
    output logic [CNT_W-1:0] tog_cnt
`endif
);

    state_t           state;
    logic             d_ref;
    logic             sample;
    logic             err;
    logic             err_inc;
    logic [CNT_W-1:0] err_next;
    logic             hit_limit;

    // A sample is taken on every enabled edge spent in CHECK.
    assign sample    = (state == ST_CHECK) && en;
    assign err       = (q != d_ref) || (qbar == q);
    assign err_inc   = sample && err;
    assign err_next  = (err_cnt == '1) ? err_cnt : err_cnt + CNT_W'(1);
    assign hit_limit = err_inc && (ERR_LIMIT != 0) && (32'(err_next) == ERR_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            mismatch <= 1'b0;
            fail     <= 1'b0;
            d_ref    <= 1'b0;
        end else if (clr) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            mismatch <= 1'b0;
            fail     <= 1'b0;
        end else begin
            mismatch <= err_inc;
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        state <= ST_PRIME;
                        busy  <= 1'b1;
                    end
                end
                ST_PRIME: begin
                    d_ref <= d;
                    state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (!en) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        d_ref <= d;
                        if (hit_limit) begin
                            state <= ST_FAIL;
                            fail  <= 1'b1;
                        end
                    end
                end
                ST_FAIL: begin
                    fail <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    dff_chk_sat_cnt #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (err_inc),
        .cnt (err_cnt)
    );

    dff_chk_sat_cnt #(.W(CNT_W)) u_chk_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (sample),
        .cnt (chk_cnt)
    );

`ifdef DFF_CHK_TOGGLE_EN
    logic q_prev;
    logic first;
    logic tog_inc;

    // The first sample after PRIME only seeds q_prev.
    assign tog_inc = sample && !first && (q != q_prev);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q_prev <= 1'b0;
            first  <= 1'b1;
        end else if (state == ST_PRIME) begin
            first <= 1'b1;
        end else if (sample) begin
            q_prev <= q;
            first  <= 1'b0;
        end
    end

    dff_chk_sat_cnt #(.W(CNT_W)) u_tog_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (tog_inc),
        .cnt (tog_cnt)
    );
`endif

endmodule

// File: tb/tb_dff_stream_checker.sv
// Directed bench for dff_stream_checker: a default instance plus a CNT_W=3,
// ERR_LIMIT=0 instance sharing the same stimulus and flip-flop model.
module tb_dff_stream_checker;

    logic clk = 1'b0;
    logic rst, en, clr, d;
    logic q_ff, inv_q, eq_qbar;
    logic q, qbar;

    logic        busy, mismatch, fail;
    logic [15:0] err_cnt, chk_cnt;
    logic        busy_s, mismatch_s, fail_s;
    logic [2:0]  err_cnt_s, chk_cnt_s;
`ifdef DFF_CHK_TOGGLE_EN
    logic [15:0] tog_cnt;
    logic [2:0]  tog_cnt_s;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Flip-flop under check, with fault injection on q and qbar.
    always_ff @(posedge clk) q_ff <= d;
    assign q    = q_ff ^ inv_q;
    assign qbar = eq_qbar ? q : ~q;

    dff_stream_checker dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (clr),
        .d        (d),
        .q        (q),
        .qbar     (qbar),
        .busy     (busy),
        .mismatch (mismatch),
        .fail     (fail),
        .err_cnt  (err_cnt),
        .chk_cnt  (chk_cnt)
`ifdef DFF_CHK_TOGGLE_EN
        ,
        .tog_cnt  (tog_cnt)
`endif
    );

    dff_stream_checker #(.CNT_W(3), .ERR_LIMIT(0)) dut_s (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (clr),
        .d        (d),
        .q        (q),
        .qbar     (qbar),
        .busy     (busy_s),
        .mismatch (mismatch_s),
        .fail     (fail_s),
        .err_cnt  (err_cnt_s),
        .chk_cnt  (chk_cnt_s)
`ifdef DFF_CHK_TOGGLE_EN
        ,
        .tog_cnt  (tog_cnt_s)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; d = 1'b0;
        inv_q = 1'b0; eq_qbar = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_mismatch", mismatch, 0);
        chk("rst_fail", fail, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_chk", chk_cnt, 0);
        rst = 1'b0;

        // Correct flip-flop, random data, en high for 11 edges: 2 edges to prime, 9 samples.
        en = 1'b1;
        for (int i = 0; i < 11; i++) begin
            d = 1'($urandom_range(0, 1));
            tick();
            chk("clean_mismatch", mismatch, 0);
        end
        chk("clean_busy", busy, 1);
        chk("clean_chk", chk_cnt, 9);
        chk("clean_err", err_cnt, 0);
        chk("clean_fail", fail, 0);
        en = 1'b0;
        tick();
        chk("clean_idle_busy", busy, 0);
        chk("clean_idle_chk_hold", chk_cnt, 9);

        // Single inverted-q sample.
        clr = 1'b1;
        tick();
        chk("clr_chk", chk_cnt, 0);
        chk("clr_err", err_cnt, 0);
        clr = 1'b0; en = 1'b1;
        tick();
        tick();
        tick();
        chk("one_chk1", chk_cnt, 1);
        chk("one_nomis", mismatch, 0);
        inv_q = 1'b1;
        tick();
        chk("one_mismatch", mismatch, 1);
        chk("one_err", err_cnt, 1);
        chk("one_chk2", chk_cnt, 2);
        inv_q = 1'b0;
        tick();
        chk("one_pulse_end", mismatch, 0);
        chk("one_err_hold", err_cnt, 1);
        chk("one_fail", fail, 0);
        chk("one_chk3", chk_cnt, 3);

        // qbar stuck equal to q for 4 samples reaches ERR_LIMIT=4.
        clr = 1'b1;
        tick();
        chk("clr2_busy", busy, 0);
        chk("clr2_err", err_cnt, 0);
        clr = 1'b0;
        tick();
        chk("prime_busy", busy, 1);
        tick();
        eq_qbar = 1'b1;
        tick();
        tick();
        tick();
        chk("lim_err3", err_cnt, 3);
        chk("lim_fail3", fail, 0);
        tick();
        chk("lim_err4", err_cnt, 4);
        chk("lim_fail4", fail, 1);
        chk("lim_mismatch4", mismatch, 1);
        chk("lim_chk4", chk_cnt, 4);
        eq_qbar = 1'b0;
        tick();
        chk("fail_chk_hold", chk_cnt, 4);
        chk("fail_err_hold", err_cnt, 4);
        chk("fail_no_mismatch", mismatch, 0);
        chk("fail_sticky", fail, 1);
        en = 1'b0;
        tick();
        chk("fail_sticky_en0", fail, 1);
        chk("fail_busy", busy, 1);
        clr = 1'b1; en = 1'b1;
        tick();
        chk("fail_clr_fail", fail, 0);
        chk("fail_clr_busy", busy, 0);
        chk("fail_clr_err", err_cnt, 0);
        chk("fail_clr_chk", chk_cnt, 0);
        clr = 1'b0;

        // Combined q+qbar error counts once; then reset mid-CHECK with err_cnt 2.
        tick();
        tick();
        inv_q = 1'b1; eq_qbar = 1'b1;
        tick();
        chk("both_err1", err_cnt, 1);
        eq_qbar = 1'b0;
        tick();
        chk("both_err2", err_cnt, 2);
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_mismatch", mismatch, 0);
        chk("mid_rst_fail", fail, 0);
        chk("mid_rst_err", err_cnt, 0);
        chk("mid_rst_chk", chk_cnt, 0);
        rst = 1'b0; inv_q = 1'b0; en = 1'b0;
        tick();

        // Narrow instance, no fail limit: continuous errors saturate at 7.
        en = 1'b1; inv_q = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 7; i++) tick();
        chk("sat_err7", err_cnt_s, 7);
        tick();
        tick();
        tick();
        chk("sat_err_hold", err_cnt_s, 7);
        chk("sat_chk_hold", chk_cnt_s, 7);
        chk("sat_fail", fail_s, 0);
        chk("sat_mismatch", mismatch_s, 1);
        en = 1'b0; inv_q = 1'b0;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;

`ifdef DFF_CHK_TOGGLE_EN
        // Samples of q: 0,1,0,1,1 -> three toggles.
        chk("tog_clr", tog_cnt, 0);
        en = 1'b1; d = 1'b0;
        tick();
        d = 1'b0;
        tick();
        d = 1'b1;
        tick();
        chk("tog_first", tog_cnt, 0);
        d = 1'b0;
        tick();
        d = 1'b1;
        tick();
        d = 1'b1;
        tick();
        tick();
        chk("tog_cnt3", tog_cnt, 3);
        chk("tog_err", err_cnt, 0);
        en = 1'b0;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
